// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-drive bundle for the ALU front-end sequencer.
// The slave modport is the sequencer. The master modport is the requester, consumer and ALU side.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             OP_VALID;
  logic             OP_READY;
  logic [2:0]       OP;
  logic [WIDTH-1:0] OPA;
  logic [WIDTH-1:0] OPB;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [2:0]       ALU_CTRL;
  logic             ALU_BINV;
  logic             ALU_CIN;
  logic [WIDTH-1:0] ALU_REZ;
  logic             ALU_COUT;
  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES;
  logic             FLAG;
  logic             ERR;

  modport slave (
    input  OP_VALID, OP, OPA, OPB, ALU_REZ, ALU_COUT, RES_READY,
    output OP_READY, ALU_A, ALU_B, ALU_CTRL, ALU_BINV, ALU_CIN, RES_VALID, RES, FLAG, ERR
  );

  modport master (
    output OP_VALID, OP, OPA, OPB, ALU_REZ, ALU_COUT, RES_READY,
    input  OP_READY, ALU_A, ALU_B, ALU_CTRL, ALU_BINV, ALU_CIN, RES_VALID, RES, FLAG, ERR
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-op front end for the shared ripple ALU.
// Logic and arithmetic ops take one ALU pass. MUL runs a WIDTH-step shift-add loop through the adder.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic            Clock,
  input  logic            Reset_n,
  alu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_XOR = 3'b100, OP_SLT = 3'b101, OP_MUL = 3'b110;
  localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_XOR = 3'b011,
                         C_LESS = 3'b101;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, flag_q, err_q;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_ctrl;
  logic             alu_binv, alu_cin, last_iter, ovf_nxt;

  assign last_iter = (cnt_q == CNT_W'(WIDTH-1));
  // a_q/b_q double as multiplicand/multiplier. A 1 leaving the multiplicand matters
  // only if multiplier bits remain that would still add it in.
  assign ovf_nxt = ovf_q | (b_q[0] & bus.ALU_COUT) | (a_q[WIDTH-1] & (|(b_q >> 1)));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 3'b000;
    alu_binv = 1'b0;
    alu_cin  = 1'b0;
    case (state_q)
      IDLE: if (bus.OP_VALID) state_d = (bus.OP == OP_MUL) ? MUL : EXEC;
      EXEC: begin
        state_d = DONE;
        if (op_q != 3'b111 && op_q != OP_MUL) begin
          alu_a = a_q;
          alu_b = b_q;
        end
        case (op_q)
          OP_AND: alu_ctrl = C_AND;
          OP_OR:  alu_ctrl = C_OR;
          OP_ADD: alu_ctrl = C_ADD;
          OP_SUB: begin alu_ctrl = C_ADD;  alu_binv = 1'b1; alu_cin = 1'b1; end
          OP_XOR: alu_ctrl = C_XOR;
          OP_SLT: begin alu_ctrl = C_LESS; alu_binv = 1'b1; alu_cin = 1'b1; end
          default: ;
        endcase
      end
      MUL: begin
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : '0;
        alu_ctrl = C_ADD;
        if (last_iter) state_d = DONE;
      end
      DONE: if (bus.RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.OP_VALID) begin
          op_q  <= bus.OP;
          a_q   <= bus.OPA;
          b_q   <= bus.OPB;
          acc_q <= '0;
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end
        EXEC: begin
          res_q  <= (op_q == 3'b111) ? '0 : bus.ALU_REZ;
          flag_q <= (op_q == OP_ADD || op_q == OP_SUB) & bus.ALU_COUT;
          err_q  <= (op_q == 3'b111);
        end
        MUL: begin
          acc_q <= bus.ALU_REZ;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          ovf_q <= ovf_nxt;
          if (last_iter) begin
            res_q  <= bus.ALU_REZ;
            flag_q <= ovf_nxt;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.OP_READY  = (state_q == IDLE);
  assign bus.RES_VALID = (state_q == DONE);
  assign bus.RES       = res_q;
  assign bus.FLAG      = flag_q;
  assign bus.ERR       = err_q;
  assign bus.ALU_A     = alu_a;
  assign bus.ALU_B     = alu_b;
  assign bus.ALU_CTRL  = alu_ctrl;
  assign bus.ALU_BINV  = alu_binv;
  assign bus.ALU_CIN   = alu_cin;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer.
// A behavioural ripple-ALU model closes the loop from the ALU_* lines back to ALU_REZ/ALU_COUT.
module tb_alu_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(W)) bus ();
  alu_sequencer #(.WIDTH(W), .CNT_W(5)) dut (.Clock(clk), .Reset_n(rst_n), .bus(bus.slave));

  logic [W-1:0] m_bb;
  logic [W:0]   m_sum;
  always_comb begin
    m_bb  = bus.ALU_BINV ? ~bus.ALU_B : bus.ALU_B;
    m_sum = {1'b0, bus.ALU_A} + {1'b0, m_bb} + {{W{1'b0}}, bus.ALU_CIN};
    bus.ALU_COUT = m_sum[W];
    case (bus.ALU_CTRL)
      3'b000:  bus.ALU_REZ = bus.ALU_A & m_bb;
      3'b001:  bus.ALU_REZ = bus.ALU_A | m_bb;
      3'b010:  bus.ALU_REZ = m_sum[W-1:0];
      3'b011:  bus.ALU_REZ = bus.ALU_A ^ m_bb;
      3'b101:  bus.ALU_REZ = {{(W-1){1'b0}}, m_sum[W-1]};
      default: bus.ALU_REZ = '0;
    endcase
  end

  int checks = 0;
  int failures = 0;

  logic [2:0]   c0;
  logic         bi0, ci0;
  logic [W-1:0] aa0, bb0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, then scrambles the inputs to prove they are ignored.
  // Checks RES_VALID timing, and captures the ALU lines of the first post-accept cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat, input logic [W-1:0] er,
                        input logic ef, input logic ee);
    chk({tag, " op_ready"}, bus.OP_READY, 1);
    bus.OP_VALID = 1'b1;
    bus.OP = op;
    bus.OPA = a;
    bus.OPB = b;
    step();
    bus.OP_VALID = 1'b0;
    bus.OP = ~op;
    bus.OPA = ~a;
    bus.OPB = ~b;
    c0 = bus.ALU_CTRL; bi0 = bus.ALU_BINV; ci0 = bus.ALU_CIN; aa0 = bus.ALU_A; bb0 = bus.ALU_B;
    for (int i = 1; i < lat; i++) begin
      if (i == lat - 1) chk({tag, " early_valid"}, bus.RES_VALID, 0);
      step();
    end
    chk({tag, " valid"}, bus.RES_VALID, 1);
    chk({tag, " res"}, bus.RES, er);
    chk({tag, " flag"}, bus.FLAG, ef);
    chk({tag, " err"}, bus.ERR, ee);
    step();
  endtask

  initial begin
    bus.OP_VALID = 1'b0;
    bus.OP = 3'b000;
    bus.OPA = '0;
    bus.OPB = '0;
    bus.RES_READY = 1'b1;

    step();
    step();
    chk("rst res_valid", bus.RES_VALID, 0);
    chk("rst res", bus.RES, 0);
    chk("rst flag", bus.FLAG, 0);
    chk("rst err", bus.ERR, 0);
    chk("rst alu_a", bus.ALU_A, 0);
    chk("rst alu_ctrl", bus.ALU_CTRL, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst op_ready", bus.OP_READY, 1);

    run_op("add_carry", 3'b010, 16'hFFFF, 16'h0001, 2, 16'h0000, 1'b1, 1'b0);
    run_op("sub", 3'b011, 16'h0005, 16'h0007, 2, 16'hFFFE, 1'b0, 1'b0);
    chk("sub ctrl", c0, 3'b010);
    chk("sub binv", bi0, 1);
    chk("sub cin", ci0, 1);
    run_op("slt", 3'b101, 16'hFFFF, 16'h0001, 2, 16'h0001, 1'b0, 1'b0);
    chk("slt ctrl", c0, 3'b101);
    run_op("and", 3'b000, 16'hF0F0, 16'h0FF0, 2, 16'h00F0, 1'b0, 1'b0);
    run_op("or", 3'b001, 16'hF0F0, 16'h0FF0, 2, 16'hFFF0, 1'b0, 1'b0);
    run_op("xor", 3'b100, 16'hF0F0, 16'h0FF0, 2, 16'hFF00, 1'b0, 1'b0);
    chk("xor ctrl", c0, 3'b011);

    run_op("mul_a", 3'b110, 16'h0123, 16'h0045, 17, 16'h4E6F, 1'b0, 1'b0);
    run_op("mul_ovf", 3'b110, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b0);
    run_op("mul_ffff", 3'b110, 16'hFFFF, 16'h0001, 17, 16'hFFFF, 1'b0, 1'b0);

    run_op("illegal", 3'b111, 16'h1234, 16'h5678, 2, 16'h0000, 1'b0, 1'b1);
    chk("illegal alu_ctrl", c0, 0);
    chk("illegal alu_a", aa0, 0);
    chk("illegal alu_b", bb0, 0);
    chk("illegal binv_cin", {bi0, ci0}, 0);
    run_op("clr_err", 3'b010, 16'h0002, 16'h0003, 2, 16'h0005, 1'b0, 1'b0);

    // Output backpressure with a queued request.
    bus.RES_READY = 1'b0;
    bus.OP_VALID = 1'b1;
    bus.OP = 3'b100;
    bus.OPA = 16'hAAAA;
    bus.OPB = 16'h5555;
    step();
    bus.OP_VALID = 1'b0;
    step();
    chk("bp valid", bus.RES_VALID, 1);
    chk("bp res", bus.RES, 16'hFFFF);
    bus.OP_VALID = 1'b1;
    bus.OP = 3'b010;
    bus.OPA = 16'h0010;
    bus.OPB = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp hold res", bus.RES, 16'hFFFF);
      chk("bp hold flag", bus.FLAG, 0);
      chk("bp hold op_ready", bus.OP_READY, 0);
      chk("bp hold valid", bus.RES_VALID, 1);
    end
    bus.RES_READY = 1'b1;
    step();
    chk("bp handoff op_ready", bus.OP_READY, 1);
    chk("bp handoff valid", bus.RES_VALID, 0);
    chk("bp handoff res kept", bus.RES, 16'hFFFF);
    step();
    bus.OP_VALID = 1'b0;
    chk("bp queued accepted", bus.OP_READY, 0);
    step();
    chk("bp queued valid", bus.RES_VALID, 1);
    chk("bp queued res", bus.RES, 16'h0030);
    step();

    // Reset in the fifth MUL cycle.
    bus.OP_VALID = 1'b1;
    bus.OP = 3'b110;
    bus.OPA = 16'h0003;
    bus.OPB = 16'h0007;
    step();
    bus.OP_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mul5 alu_ctrl", bus.ALU_CTRL, 3'b010);
    chk("mul5 alu_a", bus.ALU_A, 16'h0015);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", bus.RES_VALID, 0);
    chk("midrst res", bus.RES, 0);
    chk("midrst flag", bus.FLAG, 0);
    chk("midrst err", bus.ERR, 0);
    chk("midrst alu_a", bus.ALU_A, 0);
    chk("midrst alu_ctrl", bus.ALU_CTRL, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("midrst op_ready", bus.OP_READY, 1);
    chk("midrst no result", bus.RES_VALID, 0);
    run_op("after_rst_add", 3'b010, 16'h0001, 16'h0001, 2, 16'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Front-end controller for the shared 16-bit ALU built from ALU_1b slices. Accepts one operation at a time over a valid/ready handshake and drives the ALU's A/B/ALUCtrl/BInvert/CIN lines. Single-cycle ops use one ALU pass. MUL uses a multi-cycle shift-add loop through the ALU adder. Results are held on a valid/ready output port until consumed.

Parameters:
WIDTH, 16, datapath width; must equal the ALU width.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
Clock  input  1  single system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
OP_VALID  input  1  request valid.
OP_READY  output  1  sequencer can accept; high only in IDLE.
OP  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 MUL, 111 illegal.
OPA  input  WIDTH  operand A.
OPB  input  WIDTH  operand B.
ALU_A  output  WIDTH  to ALU A.
ALU_B  output  WIDTH  to ALU B.
ALU_CTRL  output  3  ALU select: 000 AND, 001 OR, 010 ADD, 011 XOR, 101 LESS.
ALU_BINV  output  1  ALU BInvert.
ALU_CIN  output  1  carry into bit 0.
ALU_REZ  input  WIDTH  ALU result; combinational from ALU_* outputs.
ALU_COUT  input  1  ALU carry out of the MSB.
RES_VALID  output  1  result available.
RES_READY  input  1  consumer accepts result.
RES  output  WIDTH  result.
FLAG  output  1  ADD/SUB: ALU_COUT. MUL: 1 iff the full product is >= 2^WIDTH. Other ops: 0.
ERR  output  1  1 for an illegal opcode.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE.
  - RES_VALID=0; RES, FLAG, ERR = 0.
  - ALU_A, ALU_B, ALU_CTRL, ALU_BINV, ALU_CIN = 0; OP_READY=1 after reset release.
  - Reset during EXEC, MUL or DONE aborts the operation. No result is emitted.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - OP_READY=1.
  - On the rising edge where OP_VALID=1, capture OP, OPA and OPB into internal registers.
  - OP=110 goes to MUL; every other opcode goes to EXEC.
  - Later changes on the OP inputs are ignored.
- EXEC (exactly 1 cycle): ALU driven from the captured registers.
  - AND: CTRL=000, BINV=0, CIN=0.
  - OR: CTRL=001, BINV=0, CIN=0.
  - ADD: CTRL=010, BINV=0, CIN=0.
  - SUB: CTRL=010, BINV=1, CIN=1.
  - XOR: CTRL=011, BINV=0, CIN=0.
  - SLT: CTRL=101, BINV=1, CIN=1.
  - At the end of the cycle, RES<=ALU_REZ and FLAG is set per the port definition. Go to DONE.
  - Illegal opcode (111): ALU lines stay 0, RES<=0, FLAG<=0, ERR<=1; go to DONE.
- MUL (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Internal registers: acc (init 0), mcand (init OPA), mplier (init OPB).
  - Each cycle: ALU_A=acc, ALU_B = mplier[0] ? mcand : 0, CTRL=010, BINV=0, CIN=0.
  - At the edge: acc<=ALU_REZ, mcand<=mcand<<1, mplier<=mplier>>1.
  - A sticky overflow bit is set when ALU_COUT=1 in an iteration where mplier[0]=1. It is also set when a 1 is shifted out of mcand while the remaining mplier (after the shift) is nonzero.
  - After iteration WIDTH-1: RES<=low WIDTH bits of the product, FLAG<=sticky overflow bit. Go to DONE.
- DONE:
  - RES_VALID=1; RES, FLAG and ERR are held stable.
  - On an edge with RES_READY=1, go to IDLE and set RES_VALID<=0 (RES retained).
  - OP_READY returns to 1 the cycle after the handoff. No same-cycle accept/complete.
- ALU lines are 0 in IDLE and DONE.
- Latency, counted from the accept edge k:
  - Single-cycle ops: RES_VALID high from edge k+2.
  - MUL: RES_VALID high from edge k+WIDTH+1.
- RES_READY held high before completion has no effect; DONE still lasts at least one cycle.
- Throughput: one op per (latency + 1) cycles when RES_READY is tied high.

Test Plan:
- Reset mid-MUL:
  - Stimulus: assert Reset_n=0 during MUL cycle 5.
  - Required: RES_VALID=0, all outputs 0, OP_READY=1 after release; the next ADD 1+1 gives RES=2.
- ADD with carry and SUB:
  - ADD 0xFFFF+0x0001: RES=0x0000, FLAG=1, RES_VALID at accept+2.
  - SUB 0x0005-0x0007: RES=0xFFFE, BINV=CIN=1 seen during EXEC.
- SLT and logic ops:
  - SLT OPA=0xFFFF (-1), OPB=0x0001: RES=0x0001.
  - AND/OR/XOR of 0xF0F0, 0x0FF0: 0x00F0 / 0xFFF0 / 0xFF00, FLAG=0.
- MUL:
  - 0x0123*0x0045: RES=0x4E6F, FLAG=0, RES_VALID exactly accept+17.
  - 0x0100*0x0100: RES=0x0000, FLAG=1.
  - 0xFFFF*0x0001: RES=0xFFFF, FLAG=0.
- Illegal opcode:
  - OP=111: ERR=1, RES=0, ALU lines stay 0 throughout.
  - The next legal op clears ERR.
- Output backpressure:
  - Hold RES_READY=0 for 10 cycles: RES/FLAG stable, OP_READY=0, new OP_VALID not accepted.
  - Release RES_READY: IDLE one cycle later, queued request accepted.
